chnl_acum_gen: RTL and testbench

Parametrised channel accumulator. Takes one column of HIT signed conv partial sums per accepted beat, with columns streamed 0..WID-1 per channel and channels streamed 0..CHNL-1. It sums each column element-wise across all CHNL channels in an internal WID-column buffer. When the last channel of a column is accepted, it emits the finished column through a valid/ready output stage. It sits between the per-path conv column engines and the next-layer feature-map writer.

---
 rtl/chnl_acum_gen.sv | 108 ++++++++++
 tb/tb_chnl_acum_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/chnl_acum_gen.sv
// Channel accumulator: sums each of WID columns element-wise over CHNL channels and
// emits every finished column through a 1-deep valid/ready register. Optional ReLU: CHNL_ACUM_RELU_EN.
module chnl_acum_gen #(
  parameter int DW   = 32,
  parameter int HIT  = 56,
  parameter int WID  = 56,
  parameter int CHNL = 64,
  parameter int AW   = DW + $clog2(CHNL)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       clr,
  input  logic [DW*HIT-1:0]                          in_data,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [AW*HIT-1:0]                          out_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [((WID > 1) ? $clog2(WID) : 1)-1:0]   out_col,
  output logic                                       frame_done
);

  localparam int CW  = (WID > 1) ? $clog2(WID) : 1;
  localparam int CHW = (CHNL > 1) ? $clog2(CHNL) : 1;
  localparam logic [CW-1:0]  COL_LAST = CW'(WID - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(CHNL - 1);

  logic [CW-1:0]       col_cnt;
  logic [CHW-1:0]      ch_cnt;
  logic [AW*HIT-1:0]   col_buf [WID];
  logic [AW*HIT-1:0]   rd_col;
  logic [AW*HIT-1:0]   acc_col;
  logic [AW*HIT-1:0]   res_col;
  logic                acc;
  logic                first_ch;
  logic                last_ch;
  logic                last_col;
  logic                out_fire;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign first_ch = (ch_cnt == '0);
  assign last_ch  = (ch_cnt == CH_LAST);
  assign last_col = (col_cnt == COL_LAST);
  assign rd_col   = col_buf[col_cnt];

  // Channel 0 overwrites, so stale buffer contents never need clearing.
  for (genvar h = 0; h < HIT; h++) begin : g_elem
    logic signed [DW-1:0] x;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] prev;
    logic signed [AW-1:0] sum;

    assign x     = in_data[h*DW +: DW];
    assign x_ext = AW'(x);
    assign prev  = rd_col[h*AW +: AW];
    assign sum   = first_ch ? x_ext : prev + x_ext;
    assign acc_col[h*AW +: AW] = sum;
`ifdef CHNL_ACUM_RELU_EN
    assign res_col[h*AW +: AW] = sum[AW-1] ? '0 : sum;
`else
    assign res_col[h*AW +: AW] = sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clr && acc && !last_ch) begin
      col_buf[col_cnt] <= acc_col;
    end
  end

  // A new last-channel beat in the handshake cycle keeps out_valid high with fresh data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt    <= '0;
      ch_cnt     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clr) begin
        col_cnt   <= '0;
        ch_cnt    <= '0;
        out_valid <= 1'b0;
      end else begin
        if (out_fire) begin
          out_valid  <= 1'b0;
          frame_done <= (out_col == COL_LAST);
        end
        if (acc) begin
          col_cnt <= last_col ? '0 : col_cnt + 1'b1;
          if (last_col) begin
            ch_cnt <= last_ch ? '0 : ch_cnt + 1'b1;
          end
          if (last_ch) begin
            out_data  <= res_col;
            out_col   <= col_cnt;
            out_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_chnl_acum_gen.sv
// Directed bench for chnl_acum_gen with DW=8, HIT=4, WID=3, CHNL=4 (AW=10).
module tb_chnl_acum_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_col;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  logic [39:0] data_q[$];
  logic [1:0]  col_q[$];
  int          fd_cnt;
  int          fd_at;
  int          ready_low;

  chnl_acum_gen #(.DW(8), .HIT(4), .WID(3), .CHNL(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_col(out_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        data_q.push_back(out_data);
        col_q.push_back(out_col);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_at = data_q.size();
      end
      if (!in_ready) ready_low++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One beat; waits (bounded) for in_ready while holding the beat.
  task automatic applyStimulus(input logic [31:0] d);
    int waits = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("in_ready_wait", 64'(waits >= 50), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic clearScoreboard();
    @(posedge clk);
    #1;
    data_q.delete();
    col_q.delete();
    fd_cnt    = 0;
    fd_at     = -1;
    ready_low = 0;
  endtask

  task automatic waitOutputs(input int n);
    int cyc = 0;
    while (data_q.size() < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    checkOutput("out_count", 64'(data_q.size()), 64'(n));
  endtask

  task automatic checkFrame(input string tag, input logic [39:0] exp0, input logic [39:0] exp1,
                            input logic [39:0] exp2);
    logic [39:0] exp_d[3];
    exp_d[0] = exp0;
    exp_d[1] = exp1;
    exp_d[2] = exp2;
    for (int i = 0; i < 3; i++) begin
      if (data_q.size() > 0) begin
        checkOutput({tag, "_data"}, 64'(data_q.pop_front()), 64'(exp_d[i]));
        checkOutput({tag, "_col"}, 64'(col_q.pop_front()), 64'(i));
      end else begin
        checkOutput({tag, "_missing"}, 64'd0, 64'd1);
      end
    end
    checkOutput({tag, "_fd_cnt"}, 64'(fd_cnt), 64'd1);
    checkOutput({tag, "_fd_at"}, 64'(fd_at), 64'd3);
  endtask

  function automatic logic [31:0] rep8(input logic [7:0] v);
    return {v, v, v, v};
  endfunction

  function automatic logic [39:0] rep10(input logic [9:0] v);
    return {v, v, v, v};
  endfunction

  function automatic logic [31:0] pat(input int c, input int w);
    logic [31:0] r;
    for (int h = 0; h < 4; h++) r[h*8 +: 8] = 8'(c*10 + w + h);
    return r;
  endfunction

  function automatic logic [39:0] pat_exp(input int w);
    logic [39:0] r;
    for (int h = 0; h < 4; h++) r[h*10 +: 10] = 10'(60 + 4*w + 4*h);
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    fd_cnt = 0; fd_at = -1; ready_low = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_out_col", 64'(out_col), 64'd0);
    checkOutput("rst_frame_done", 64'(frame_done), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    clearScoreboard();

    $display("[TB] frame of ones");
    for (int i = 0; i < 12; i++) applyStimulus(rep8(8'd1));
    waitOutputs(3);
    checkOutput("ones_ready_low", 64'(ready_low), 64'd0);
    checkFrame("ones", rep10(10'd4), rep10(10'd4), rep10(10'd4));
    clearScoreboard();

    $display("[TB] frame of -128");
    for (int i = 0; i < 12; i++) applyStimulus(rep8(8'h80));
    waitOutputs(3);
`ifdef CHNL_ACUM_RELU_EN
    checkFrame("neg", rep10(10'd0), rep10(10'd0), rep10(10'd0));
`else
    checkFrame("neg", rep10(10'h200), rep10(10'h200), rep10(10'h200));
`endif
    clearScoreboard();

    $display("[TB] pattern frame with output backpressure");
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(pat(i / 3, i % 3));
    @(negedge clk);
    in_data  = pat(3, 1);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      checkOutput("hold_out_data", 64'(out_data), 64'(pat_exp(0)));
      checkOutput("hold_out_col", 64'(out_col), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    applyStimulus(pat(3, 2));
    waitOutputs(3);
    checkFrame("pat", pat_exp(0), pat_exp(1), pat_exp(2));
    clearScoreboard();

    $display("[TB] clear mid-frame");
    for (int i = 0; i < 7; i++) applyStimulus(rep8(8'd1));
    @(negedge clk);
    in_data = rep8(8'd1); in_valid = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; clr = 1'b0;
    checkOutput("clr_no_output", 64'(data_q.size()), 64'd0);
    for (int i = 0; i < 12; i++) applyStimulus(rep8(8'd1));
    waitOutputs(3);
    checkFrame("clr", rep10(10'd4), rep10(10'd4), rep10(10'd4));
    clearScoreboard();

    $display("[TB] async reset mid-frame");
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(rep8(8'd1));
    @(negedge clk);
    checkOutput("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_out_data", 64'(out_data), 64'd0);
    checkOutput("arst_out_col", 64'(out_col), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    clearScoreboard();
    for (int i = 0; i < 12; i++) applyStimulus(rep8(8'd2));
    waitOutputs(3);
    checkFrame("twos", rep10(10'd8), rep10(10'd8), rep10(10'd8));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
